// File: rtl/avalon_mm_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_mm_arbiter_2to1_if
//  Purpose  : Avalon-MM command/response bundle with pipelined read data and
//             write responses. The same interface type is used for both host
//             ports and the agent port of the 2:1 arbiter.
//  Modports : master - drives read/write/address/writedata/byteenable,
//                      samples waitrequest and the response signals.
//             slave  - the mirror image of master.
//  Signals  : read, write, address[ADDR_WIDTH], writedata[DATA_WIDTH],
//             byteenable[DATA_WIDTH/8], waitrequest, readdatavalid,
//             writeresponsevalid, readdata[DATA_WIDTH], response[2]
//  Revision : 1.0 - initial release
// ============================================================================
interface avalon_mm_arbiter_2to1_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      waitrequest;
    logic                      readdatavalid;
    logic                      writeresponsevalid;
    logic [DATA_WIDTH-1:0]     readdata;
    logic [1:0]                response;

    modport master (
        output read, write, address, writedata, byteenable,
        input  waitrequest, readdatavalid, writeresponsevalid, readdata, response
    );

    modport slave (
        input  read, write, address, writedata, byteenable,
        output waitrequest, readdatavalid, writeresponsevalid, readdata, response
    );
endinterface
`default_nettype wire

// File: rtl/avalon_mm_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_mm_arbiter_2to1
//  Purpose  : Round-robin arbiter sharing one Avalon-MM agent between two
//             Avalon-MM hosts. Commands pass through combinationally; the
//             issuing host of each accepted command is queued in an in-order
//             tag FIFO so pipelined read/write responses return to it.
//  Ports    : clk - clock, all state on the rising edge
//             rst - asynchronous active-high reset
//             h0  - host 0 (slave modport: the host drives commands in)
//             h1  - host 1 (slave modport)
//             a   - downstream agent (master modport)
//  Params   : DATA_WIDTH      - data width, multiple of 8
//             ADDR_WIDTH      - word address width
//             MAX_OUTSTANDING - tag FIFO depth, power of 2, >= 2
//  Revision : 1.0 - initial release
// ============================================================================
module avalon_mm_arbiter_2to1 #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    avalon_mm_arbiter_2to1_if.slave    h0,
    avalon_mm_arbiter_2to1_if.slave    h1,
    avalon_mm_arbiter_2to1_if.master   a
);

    localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_be_w  = DATA_WIDTH / 8;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_owner;
    logic                 r_prio;
    logic                 r_tag [MAX_OUTSTANDING];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_cnt_w-1:0]   r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_owner_nxt;
    logic                 w_req0;
    logic                 w_req1;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_gnt_vld;
    logic                 w_gnt_id;
    logic                 w_sel_read;
    logic                 w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [c_be_w-1:0]    w_sel_be;
    logic                 w_a_read;
    logic                 w_a_write;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_rsp;
    logic                 w_pop;
    logic                 w_head;

    assign w_req0  = h0.read | h0.write;
    assign w_req1  = h1.read | h1.write;
    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------
    // Grant: combinational in IDLE, held by the owner register in LOCKED.
    // Reset forces "nothing granted" so no command leaks out while rst is
    // high, independent of the state registers.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_full && (w_req0 || w_req1)) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = (w_req0 && w_req1) ? r_prio : w_req1;
                    end
                end
                S_LOCKED: begin
                    w_gnt_vld = 1'b1;
                    w_gnt_id  = r_owner;
                end
                default: begin
                    w_gnt_vld = 1'b0;
                    w_gnt_id  = 1'b0;
                end
            endcase
        end
    end

    // Command mux; with no grant w_gnt_id is 0, so host 0's fields appear
    // on the agent bus while the strobes are held low.
    assign w_sel_read  = w_gnt_id ? h1.read       : h0.read;
    assign w_sel_write = w_gnt_id ? h1.write      : h0.write;
    assign w_sel_addr  = w_gnt_id ? h1.address    : h0.address;
    assign w_sel_wdata = w_gnt_id ? h1.writedata  : h0.writedata;
    assign w_sel_be    = w_gnt_id ? h1.byteenable : h0.byteenable;

    assign w_a_read  = w_gnt_vld & w_sel_read;
    assign w_a_write = w_gnt_vld & w_sel_write;
    assign w_accept  = (w_a_read | w_a_write) & ~a.waitrequest;
    assign w_push    = w_accept;

    assign a.read       = w_a_read;
    assign a.write      = w_a_write;
    assign a.address    = w_sel_addr;
    assign a.writedata  = w_sel_wdata;
    assign a.byteenable = w_sel_be;

    assign h0.waitrequest = (w_gnt_vld && !w_gnt_id) ? a.waitrequest : 1'b1;
    assign h1.waitrequest = (w_gnt_vld &&  w_gnt_id) ? a.waitrequest : 1'b1;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                // A stalled grant is pinned to its host until accepted so
                // the agent sees a stable command for the whole stall.
                if ((w_a_read || w_a_write) && !w_accept) begin
                    w_state_nxt = S_LOCKED;
                    w_owner_nxt = w_gnt_id;
                end
            end
            S_LOCKED: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response routing. Strobes arriving with an empty FIFO have no owner
    // and are dropped without touching the read pointer.
    // ------------------------------------------------------------------
    assign w_rsp  = a.readdatavalid | a.writeresponsevalid;
    assign w_pop  = w_rsp & ~w_empty & ~rst;
    assign w_head = r_tag[r_rptr];

    assign h0.readdata = a.readdata;
    assign h1.readdata = a.readdata;
    assign h0.response = a.response;
    assign h1.response = a.response;

    assign h0.readdatavalid      = w_pop & ~w_head & a.readdatavalid;
    assign h0.writeresponsevalid = w_pop & ~w_head & a.writeresponsevalid;
    assign h1.readdatavalid      = w_pop &  w_head & a.readdatavalid;
    assign h1.writeresponsevalid = w_pop &  w_head & a.writeresponsevalid;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            if (w_accept) begin
                r_prio <= ~w_gnt_id;
            end
        end
    end

    // Tag FIFO. Push cannot happen while full: IDLE withholds the grant and
    // LOCKED is only entered from a non-full IDLE, after which only pops occur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag[i] <= 1'b0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_gnt_id;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_mm_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_mm_arbiter_2to1
//  Purpose  : Directed self-checking bench for avalon_mm_arbiter_2to1.
//             Inputs change just after the falling edge; the combinational
//             outputs are checked 1 ns later, well before the next rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_mm_arbiter_2to1;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    avalon_mm_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h0_if ();
    avalon_mm_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h1_if ();
    avalon_mm_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();

    avalon_mm_arbiter_2to1 #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .h0  (h0_if),
        .h1  (h1_if),
        .a   (a_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        h0_if.read = 1'b0; h0_if.write = 1'b0; h0_if.address = '0;
        h0_if.writedata = '0; h0_if.byteenable = '1;
        h1_if.read = 1'b0; h1_if.write = 1'b0; h1_if.address = '0;
        h1_if.writedata = '0; h1_if.byteenable = '1;
        a_if.waitrequest = 1'b0; a_if.readdatavalid = 1'b0;
        a_if.writeresponsevalid = 1'b0; a_if.readdata = '0; a_if.response = 2'b00;
    endtask

    // Starts a new cycle: inputs may be changed after this returns.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // ---------------- Reset state ----------------
        h0_if.read = 1'b1; h0_if.address = 32'h44;
        a_if.readdatavalid = 1'b1;
        #1;
        chk("rst_h0_wait", h0_if.waitrequest, 1);
        chk("rst_h1_wait", h1_if.waitrequest, 1);
        chk("rst_a_read",  a_if.read, 0);
        chk("rst_h0_rdv",  h0_if.readdatavalid, 0);
        chk("rst_h1_rdv",  h1_if.readdatavalid, 0);
        do_reset();

        // ---------------- Single host read ----------------
        next_cycle();
        h0_if.read = 1'b1; h0_if.address = 32'h10;
        #1;
        chk("rd_a_read", a_if.read, 1);
        chk("rd_a_addr", a_if.address, 32'h10);
        chk("rd_h0_wait", h0_if.waitrequest, 0);
        chk("rd_h1_wait", h1_if.waitrequest, 1);
        next_cycle();
        h0_if.read = 1'b0;
        a_if.readdatavalid = 1'b1; a_if.readdata = 32'hDEADBEEF;
        #1;
        chk("rd_h0_rdv",  h0_if.readdatavalid, 1);
        chk("rd_h0_data", h0_if.readdata, 32'hDEADBEEF);
        chk("rd_h1_rdv",  h1_if.readdatavalid, 0);
        chk("rd_h1_wrv",  h1_if.writeresponsevalid, 0);
        next_cycle();
        clear_inputs();

        // ---------------- Contention after reset ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            h0_if.write = (i < 4); h0_if.address = 32'h100;
            h1_if.write = (i < 4); h1_if.address = 32'h200;
            a_if.writeresponsevalid = (i >= 1);
            #1;
            if (i < 4) begin
                chk($sformatf("cont_a_write_%0d", i), a_if.write, 1);
                chk($sformatf("cont_a_addr_%0d", i), a_if.address,
                    (i % 2 == 0) ? 32'h100 : 32'h200);
                chk($sformatf("cont_h0_wait_%0d", i), h0_if.waitrequest, (i % 2 == 0) ? 0 : 1);
            end
            if (i >= 1) begin
                chk($sformatf("cont_h0_wrv_%0d", i), h0_if.writeresponsevalid,
                    ((i - 1) % 2 == 0) ? 1 : 0);
                chk($sformatf("cont_h1_wrv_%0d", i), h1_if.writeresponsevalid,
                    ((i - 1) % 2 == 1) ? 1 : 0);
            end
        end
        next_cycle();
        clear_inputs();

        // ---------------- Stall lock ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            h1_if.write = (i < 4); h1_if.address = 32'h300; h1_if.writedata = 32'hCAFE0001;
            h0_if.read  = (i >= 1); h0_if.address = 32'h400;
            a_if.waitrequest = (i < 3);
            #1;
            if (i < 4) begin
                chk($sformatf("lock_a_addr_%0d", i), a_if.address, 32'h300);
                chk($sformatf("lock_a_write_%0d", i), a_if.write, 1);
                chk($sformatf("lock_h0_wait_%0d", i), h0_if.waitrequest, 1);
            end else begin
                chk("lock_h0_next_addr", a_if.address, 32'h400);
                chk("lock_h0_next_read", a_if.read, 1);
                chk("lock_h0_next_wait", h0_if.waitrequest, 0);
            end
        end
        next_cycle();
        clear_inputs();
        a_if.writeresponsevalid = 1'b1;
        #1;
        chk("lock_rsp_h1_wrv", h1_if.writeresponsevalid, 1);
        chk("lock_rsp_h0_wrv", h0_if.writeresponsevalid, 0);
        next_cycle();
        a_if.writeresponsevalid = 1'b0; a_if.readdatavalid = 1'b1;
        #1;
        chk("lock_rsp_h0_rdv", h0_if.readdatavalid, 1);
        chk("lock_rsp_h1_rdv", h1_if.readdatavalid, 0);
        next_cycle();
        clear_inputs();

        // ---------------- FIFO full ----------------
        do_reset();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            h0_if.read = 1'b1; h0_if.address = 32'h20;
            a_if.readdatavalid = (i == 5);
            #1;
            if (i < 4) begin
                chk($sformatf("full_fill_wait_%0d", i), h0_if.waitrequest, 0);
            end else if (i < 6) begin
                chk($sformatf("full_wait_%0d", i), h0_if.waitrequest, 1);
                chk($sformatf("full_a_read_%0d", i), a_if.read, 0);
                if (i == 5) chk("full_pop_rdv", h0_if.readdatavalid, 1);
            end else begin
                chk("full_after_pop_wait", h0_if.waitrequest, 0);
                chk("full_after_pop_read", a_if.read, 1);
            end
        end
        next_cycle();
        clear_inputs();

        // ---------------- Push/pop same cycle with pointer wrap ----------------
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            next_cycle();
            h0_if.read = (k <= 10); h0_if.address = 32'h500;
            h1_if.read = (k <= 10); h1_if.address = 32'h600;
            a_if.readdatavalid = (k >= 1);
            a_if.readdata = 32'hA000_0000 + k;
            #1;
            if (k <= 10) begin
                chk($sformatf("wrap_a_addr_%0d", k), a_if.address,
                    (k % 2 == 0) ? 32'h500 : 32'h600);
            end
            if (k >= 1 && k <= 11) begin
                chk($sformatf("wrap_h0_rdv_%0d", k), h0_if.readdatavalid,
                    ((k - 1) % 2 == 0) ? 1 : 0);
                chk($sformatf("wrap_h1_rdv_%0d", k), h1_if.readdatavalid,
                    ((k - 1) % 2 == 1) ? 1 : 0);
            end
            if (k == 12) begin
                chk("wrap_stray_h0", h0_if.readdatavalid, 0);
                chk("wrap_stray_h1", h1_if.readdatavalid, 0);
            end
        end
        next_cycle();
        clear_inputs();

        // ---------------- Reset mid-transaction ----------------
        do_reset();
        next_cycle();
        h0_if.read = 1'b1; h0_if.address = 32'h700;
        next_cycle();
        h0_if.read = 1'b0;
        h1_if.read = 1'b1; h1_if.address = 32'h704;
        next_cycle();
        h1_if.read = 1'b0;
        h0_if.write = 1'b1; h0_if.address = 32'h708;
        a_if.waitrequest = 1'b1;
        #1;
        chk("mid_locked_wait", h0_if.waitrequest, 1);
        next_cycle();
        rst = 1'b1;
        a_if.readdatavalid = 1'b1;
        #1;
        chk("mid_rst_h0_wait", h0_if.waitrequest, 1);
        chk("mid_rst_h1_wait", h1_if.waitrequest, 1);
        chk("mid_rst_a_write", a_if.write, 0);
        chk("mid_rst_a_read",  a_if.read, 0);
        chk("mid_rst_h0_rdv",  h0_if.readdatavalid, 0);
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        a_if.readdatavalid = 1'b1;
        #1;
        chk("mid_stray_h0_rdv", h0_if.readdatavalid, 0);
        chk("mid_stray_h1_rdv", h1_if.readdatavalid, 0);
        next_cycle();
        clear_inputs();
        h1_if.write = 1'b1; h1_if.address = 32'h70C;
        #1;
        chk("mid_idle_a_write", a_if.write, 1);
        chk("mid_idle_a_addr",  a_if.address, 32'h70C);
        chk("mid_idle_h1_wait", h1_if.waitrequest, 0);
        next_cycle();
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
